// File: rtl/rf_wb_if.sv
// rf_wb_if: register-file writeback bus between two requesters and the
// write-port arbiter.
//   req0_*          : in-order pipeline writeback request (valid/rd/data, ready back)
//   req1_*          : long-latency unit return request (valid/rd/data, ready back)
//   rddata_wr       : register-file write data
//   rdsel_wr        : register-file destination select
//   phase_writeback : register-file write enable, one-cycle pulse
//   starve_cnt      : current req1 wait count (debug)
// Modports: master = requester/register-file side, slave = arbiter side.
interface rf_wb_if #(
    parameter int XLEN = 32
);
    logic            req0_valid;
    logic [4:0]      req0_rd;
    logic [XLEN-1:0] req0_data;
    logic            req0_ready;

    logic            req1_valid;
    logic [4:0]      req1_rd;
    logic [XLEN-1:0] req1_data;
    logic            req1_ready;

    logic [XLEN-1:0] rddata_wr;
    logic [4:0]      rdsel_wr;
    logic            phase_writeback;
    logic [3:0]      starve_cnt;

    modport master (
        output req0_valid, req0_rd, req0_data,
        input  req0_ready,
        output req1_valid, req1_rd, req1_data,
        input  req1_ready,
        input  rddata_wr, rdsel_wr, phase_writeback, starve_cnt
    );

    modport slave (
        input  req0_valid, req0_rd, req0_data,
        output req0_ready,
        input  req1_valid, req1_rd, req1_data,
        output req1_ready,
        output rddata_wr, rdsel_wr, phase_writeback, starve_cnt
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the single register-file write port between the
// pipeline writeback (req0, fixed priority) and the long-latency unit (req1).
// A saturating starvation counter forces a req1 grant once req1 has waited
// STARVE_MAX consecutive cycles. The granted write is registered (one cycle
// from transfer to phase_writeback); writes to x0 are accepted but squashed.
//   clk : clock
//   rst : synchronous reset, active-high
//   bus : rf_wb_if slave modport (requests, readys, write port, starve_cnt)
module rf_wb_arbiter #(
    parameter int XLEN       = 32,
    parameter int STARVE_MAX = 4    // legal range 1..15
) (
    input  logic    clk,
    input  logic    rst,
    rf_wb_if.slave  bus
);

    typedef enum logic {
        PRIO0,
        FORCE1
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t          state, state_next;
    logic            grant0, grant1;
    logic [3:0]      cnt_q, cnt_next;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_data;
    logic            wr_en;

    logic            wb_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] data_q;

    // Grant, counter and next-state logic.
    // NOTE: every always_comb output gets a default first so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        grant0     = 1'b0;
        grant1     = 1'b0;
        cnt_next   = cnt_q;
        state_next = state;

        // No transfer is possible during a reset cycle.
        if (!rst) begin
            // FORCE1 only overrides when req1 is still asking; a withdrawn
            // req1 falls straight through to the normal priority order.
            if (state == FORCE1 && bus.req1_valid) begin
                grant1 = 1'b1;
            end else if (bus.req0_valid) begin
                grant0 = 1'b1;
            end else if (bus.req1_valid) begin
                grant1 = 1'b1;
            end
        end

        if (!bus.req1_valid || grant1) begin
            cnt_next = 4'd0;
        end else if (cnt_q != 4'hF) begin
            cnt_next = cnt_q + 4'd1;
        end

        case (state)
            PRIO0:  if (cnt_next >= STARVE_LIM) state_next = FORCE1;
            FORCE1: if (grant1 || !bus.req1_valid) state_next = PRIO0;
            default: state_next = PRIO0;
        endcase
    end

    assign sel_rd   = grant1 ? bus.req1_rd   : bus.req0_rd;
    assign sel_data = grant1 ? bus.req1_data : bus.req0_data;
    // x0 transfers complete the handshake but never reach the register file.
    assign wr_en    = (grant0 || grant1) && (sel_rd != 5'd0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= PRIO0;
            cnt_q <= 4'd0;
        end else begin
            state <= state_next;
            cnt_q <= cnt_next;
        end
    end

    // Output stage: rd/data only update on a real write so they hold their
    // last value between pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_q   <= 1'b0;
            rd_q   <= 5'd0;
            data_q <= '0;
        end else begin
            wb_q <= wr_en;
            if (wr_en) begin
                rd_q   <= sel_rd;
                data_q <= sel_data;
            end
        end
    end

    assign bus.req0_ready      = grant0;
    assign bus.req1_ready      = grant1;
    // A write registered just before reset is dropped in the reset cycle.
    assign bus.phase_writeback = wb_q && !rst;
    assign bus.rdsel_wr        = rd_q;
    assign bus.rddata_wr       = data_q;
    assign bus.starve_cnt      = cnt_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed self-checking bench for rf_wb_arbiter
// (XLEN=32, STARVE_MAX=4). Inputs change 1 time unit after the rising edge;
// outputs are sampled there as well, away from the active edge.
module tb_rf_wb_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    rf_wb_if #(.XLEN(32)) bus();

    rf_wb_arbiter #(
        .XLEN       (32),
        .STARVE_MAX (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic v, input logic [4:0] rd, input logic [31:0] d);
        bus.req0_valid = v;
        bus.req0_rd    = rd;
        bus.req0_data  = d;
    endtask

    task automatic drive1(input logic v, input logic [4:0] rd, input logic [31:0] d);
        bus.req1_valid = v;
        bus.req1_rd    = rd;
        bus.req1_data  = d;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        drive0(1'b0, 5'd0, 32'h0);
        drive1(1'b0, 5'd0, 32'h0);
        tick();
        tick();

        // Reset state
        check("rst_wb",    {31'b0, bus.phase_writeback}, 32'd0);
        check("rst_rdsel", {27'b0, bus.rdsel_wr},        32'd0);
        check("rst_data",  bus.rddata_wr,                32'd0);
        check("rst_cnt",   {28'b0, bus.starve_cnt},      32'd0);
        check("rst_rdy0",  {31'b0, bus.req0_ready},      32'd0);
        rst = 1'b0;
        tick();
        check("idle_rdy0", {31'b0, bus.req0_ready}, 32'd0);
        check("idle_rdy1", {31'b0, bus.req1_ready}, 32'd0);

        // Single req0
        drive0(1'b1, 5'd5, 32'hDEADBEEF);
        #1;
        check("single_rdy0", {31'b0, bus.req0_ready}, 32'd1);
        check("single_rdy1", {31'b0, bus.req1_ready}, 32'd0);
        check("single_wb_early", {31'b0, bus.phase_writeback}, 32'd0);
        tick();
        drive0(1'b0, 5'd0, 32'h0);
        check("single_wb",    {31'b0, bus.phase_writeback}, 32'd1);
        check("single_rdsel", {27'b0, bus.rdsel_wr},        32'd5);
        check("single_data",  bus.rddata_wr,                32'hDEADBEEF);
        tick();
        check("single_wb_off", {31'b0, bus.phase_writeback}, 32'd0);
        check("single_hold",   {27'b0, bus.rdsel_wr},        32'd5);

        // Priority: req0 wins, req1 follows with no bubble
        drive0(1'b1, 5'd3, 32'h33);
        drive1(1'b1, 5'd7, 32'h77);
        #1;
        check("prio_rdy0", {31'b0, bus.req0_ready}, 32'd1);
        check("prio_rdy1", {31'b0, bus.req1_ready}, 32'd0);
        tick();
        drive0(1'b0, 5'd0, 32'h0);
        #1;
        check("prio_rdsel3", {27'b0, bus.rdsel_wr},   32'd3);
        check("prio_cnt1",   {28'b0, bus.starve_cnt}, 32'd1);
        check("prio_rdy1b",  {31'b0, bus.req1_ready}, 32'd1);
        tick();
        drive1(1'b0, 5'd0, 32'h0);
        check("prio_rdsel7", {27'b0, bus.rdsel_wr},        32'd7);
        check("prio_data7",  bus.rddata_wr,                32'h77);
        check("prio_wb7",    {31'b0, bus.phase_writeback}, 32'd1);
        check("prio_cnt0",   {28'b0, bus.starve_cnt},      32'd0);
        tick();

        // Starvation with STARVE_MAX=4
        drive0(1'b1, 5'd10, 32'hA0A0);
        drive1(1'b1, 5'd9,  32'h9999);
        for (int i = 1; i <= 4; i++) begin
            #1;
            check($sformatf("starve_rdy1_%0d", i), {31'b0, bus.req1_ready}, 32'd0);
            check($sformatf("starve_rdy0_%0d", i), {31'b0, bus.req0_ready}, 32'd1);
            tick();
            check($sformatf("starve_cnt_%0d", i), {28'b0, bus.starve_cnt}, 32'(i));
        end
        #1;
        check("force_rdy1", {31'b0, bus.req1_ready}, 32'd1);
        check("force_rdy0", {31'b0, bus.req0_ready}, 32'd0);
        tick();
        drive1(1'b0, 5'd0, 32'h0);
        check("force_cnt0",  {28'b0, bus.starve_cnt}, 32'd0);
        check("force_rdsel", {27'b0, bus.rdsel_wr},   32'd9);
        check("force_data",  bus.rddata_wr,           32'h9999);
        #1;
        check("after_force_rdy0", {31'b0, bus.req0_ready}, 32'd1);
        tick();
        drive0(1'b0, 5'd0, 32'h0);
        check("after_force_rdsel", {27'b0, bus.rdsel_wr}, 32'd10);
        tick();

        // x0 squash
        drive1(1'b1, 5'd0, 32'h1234);
        #1;
        check("x0_rdy1", {31'b0, bus.req1_ready}, 32'd1);
        tick();
        drive1(1'b0, 5'd0, 32'h0);
        check("x0_wb",    {31'b0, bus.phase_writeback}, 32'd0);
        check("x0_rdsel", {27'b0, bus.rdsel_wr},        32'd10);
        check("x0_data",  bus.rddata_wr,                32'hA0A0);
        tick();

        // Reset mid-operation: transfer at N, rst during N+1
        drive0(1'b1, 5'd12, 32'hC0DE);
        drive1(1'b1, 5'd4,  32'h4444);
        #1;
        check("mid_rdy0", {31'b0, bus.req0_ready}, 32'd1);
        tick();
        check("mid_cnt1", {28'b0, bus.starve_cnt}, 32'd1);
        rst = 1'b1;
        #1;
        check("mid_wb_n1",  {31'b0, bus.phase_writeback}, 32'd0);
        check("mid_rdy0_r", {31'b0, bus.req0_ready},      32'd0);
        check("mid_rdy1_r", {31'b0, bus.req1_ready},      32'd0);
        tick();
        rst = 1'b0;
        drive0(1'b0, 5'd0, 32'h0);
        drive1(1'b0, 5'd0, 32'h0);
        check("mid_wb_n2", {31'b0, bus.phase_writeback}, 32'd0);
        check("mid_rdsel", {27'b0, bus.rdsel_wr},        32'd0);
        check("mid_data",  bus.rddata_wr,                32'd0);
        check("mid_cnt0",  {28'b0, bus.starve_cnt},      32'd0);
        // Back in PRIO0: req0 wins a tie
        drive0(1'b1, 5'd2, 32'h22);
        drive1(1'b1, 5'd6, 32'h66);
        #1;
        check("mid_prio0_rdy0", {31'b0, bus.req0_ready}, 32'd1);
        check("mid_prio0_rdy1", {31'b0, bus.req1_ready}, 32'd0);
        drive0(1'b0, 5'd0, 32'h0);
        drive1(1'b0, 5'd0, 32'h0);
        tick();
        tick();

        // Streaming: 8 back-to-back req0 writes
        for (int i = 1; i <= 8; i++) begin
            drive0(1'b1, 5'(i), 32'h100 + 32'(i));
            #1;
            check($sformatf("stream_rdy_%0d", i), {31'b0, bus.req0_ready}, 32'd1);
            tick();
            check($sformatf("stream_wb_%0d", i),    {31'b0, bus.phase_writeback}, 32'd1);
            check($sformatf("stream_rdsel_%0d", i), {27'b0, bus.rdsel_wr},        32'(i));
            check($sformatf("stream_data_%0d", i),  bus.rddata_wr,                32'h100 + 32'(i));
        end
        drive0(1'b0, 5'd0, 32'h0);
        tick();
        check("stream_end_wb", {31'b0, bus.phase_writeback}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Shares the single register-file write port (rddata_wr / rdsel_wr / phase_writeback) between two requesters. Requester 0 is the in-order pipeline writeback; requester 1 is the long-latency unit (load / multiply-divide return). Fixed priority to requester 0, with a starvation counter that forces a requester-1 grant. The write command is registered, and x0 writes are squashed.

Parameters:
XLEN, 32, data width; must match the register file.
STARVE_MAX, 4, number of consecutive cycles req1 may wait while req0 wins before req1 is forced; legal range 1..15.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
req0_valid  in  1  pipeline writeback request
req0_rd  in  5  destination register for req0
req0_data  in  XLEN  write data for req0
req0_ready  out  1  req0 accepted this cycle
req1_valid  in  1  long-latency unit request
req1_rd  in  5  destination register for req1
req1_data  in  XLEN  write data for req1
req1_ready  out  1  req1 accepted this cycle
rddata_wr  out  XLEN  register-file write data
rdsel_wr  out  5  register-file destination select
phase_writeback  out  1  register-file write enable, one-cycle pulse
starve_cnt  out  4  current req1 wait count (debug)

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: rddata_wr=0, rdsel_wr=0, phase_writeback=0, starve_cnt=0, state=PRIO0.
- Handshake: a request transfers when valid && ready on the same clk edge. ready is combinational from the valid inputs and the state. Requester data must stay stable while valid=1 and ready=0.
- At most one ready is high per cycle. When both valids are low, both readys are low.
- State PRIO0:
  - If req0_valid, grant req0.
  - Otherwise, if req1_valid, grant req1.
- State FORCE1:
  - If req1_valid, grant req1, even if req0_valid.
  - If req1_valid=0 (request withdrawn), fall back to PRIO0 rules in the same cycle.
- Starvation counter:
  - Increments, saturating at 15, when req1_valid && !req1_ready.
  - Clears on a req1 grant, or when req1_valid=0.
- Transitions:
  - PRIO0 -> FORCE1 when the counter's next value is >= STARVE_MAX.
  - FORCE1 -> PRIO0 after one req1 grant, or when req1_valid=0.
- Output stage: the granted rd/data are registered, so there is 1-cycle latency from transfer to phase_writeback.
  - phase_writeback=1 for exactly one cycle per transfer whose rd != 0.
  - rdsel_wr and rddata_wr hold their last value when phase_writeback=0.
- x0 rule: a transfer with rd=0 is accepted (ready=1), but phase_writeback stays 0 and the output registers do not update.
- Throughput: one write per cycle. Back-to-back grants are allowed with no bubble.
- Ordering: if both requesters target the same rd in consecutive cycles, register-file contents follow grant order (the last write wins). The arbiter does no rd comparison.
- Reset mid-operation: on a rst cycle both readys are 0 and no transfer occurs. An in-flight registered write is dropped (phase_writeback=0 the next cycle). State returns to PRIO0 and the counter to 0.

Test Plan:
- Single req0: req0_valid=1, rd=5, data=0xDEADBEEF for one cycle -> req0_ready=1 that cycle; next cycle phase_writeback=1, rdsel_wr=5, rddata_wr=0xDEADBEEF; then phase_writeback=0.
- Priority: both valid in the same cycle (req0 rd=3, req1 rd=7) -> req0_ready=1, req1_ready=0; next cycle rdsel_wr=3 and req1_ready=1 (req0 idle); the cycle after, rdsel_wr=7.
- Starvation, STARVE_MAX=4: req0_valid held 1 continuously, req1_valid=1, rd=9 -> req1_ready=0 for 4 cycles with starve_cnt counting 1,2,3,4; cycle 5: req1_ready=1, req0_ready=0, starve_cnt then 0; cycle 6 onward: req0 wins again.
- x0 squash: req1 rd=0, data=0x1234 -> req1_ready=1; phase_writeback stays 0; rdsel_wr/rddata_wr unchanged.
- Reset mid-operation: req0 transfers rd=12 at cycle N, rst=1 at cycle N+1 -> phase_writeback=0 at N+1 and N+2; all outputs 0; state PRIO0; starve_cnt=0.
- Streaming: req0 valid for 8 consecutive cycles with rd=1..8 -> 8 consecutive phase_writeback pulses, rdsel_wr=1..8 in order, delayed by 1 cycle.
